// File: rtl/multi_cycle_unit_pkg.sv
// Shared definitions for the multi-cycle MUL/DIV unit.
//   - opcode values for the multiply and divide instructions
//   - FSM state type and accumulate-mode type
//   - opcode class helpers (multiply class, divide class, signed, accumulate)
package multi_cycle_unit_pkg;

  localparam int unsigned INST_MULT  = 32'h18;
  localparam int unsigned INST_MULTU = 32'h19;
  localparam int unsigned INST_DIV   = 32'h1A;
  localparam int unsigned INST_DIVU  = 32'h1B;
  localparam int unsigned INST_MADD  = 32'hA6;
  localparam int unsigned INST_MADDU = 32'hA8;
  localparam int unsigned INST_MSUB  = 32'hAA;
  localparam int unsigned INST_MSUBU = 32'hAB;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } mcu_state_e;

  typedef enum logic [1:0] {
    AccNone,
    AccAdd,
    AccSub
  } acc_mode_e;

  function automatic logic is_mul_class(input logic [31:0] op);
    return (op == INST_MULT) || (op == INST_MULTU) || (op == INST_MADD) ||
           (op == INST_MADDU) || (op == INST_MSUB) || (op == INST_MSUBU);
  endfunction

  function automatic logic is_div_class(input logic [31:0] op);
    return (op == INST_DIV) || (op == INST_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [31:0] op);
    return (op == INST_MULT) || (op == INST_MADD) || (op == INST_MSUB) || (op == INST_DIV);
  endfunction

  function automatic acc_mode_e acc_mode(input logic [31:0] op);
    if ((op == INST_MADD) || (op == INST_MADDU)) return AccAdd;
    if ((op == INST_MSUB) || (op == INST_MSUBU)) return AccSub;
    return AccNone;
  endfunction

endpackage

// File: rtl/div_iter_unsigned.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle, MSB first.
//   clk, rst_n          : clock, async active-low reset
//   load                : capture dividend/divisor and start WIDTH iterations
//   abort               : drop any iteration in progress
//   dividend, divisor   : unsigned operands
//   quotient, remainder : results, final once valid is high
//   valid               : high from the cycle after the last iteration until next load/abort
module div_iter_unsigned #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;  // holds unshifted dividend bits on top, quotient bits below
  logic [WIDTH-1:0] r_div;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_valid;

  logic [WIDTH:0]   w_shift;  // W+1-bit partial remainder
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_div};
  // True difference is below the divisor, so W bits hold it exactly.
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (abort) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_rem   <= '0;
      r_quo   <= dividend;
      r_div   <= divisor;
      r_cnt   <= CntW'(WIDTH - 1);
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      if (r_cnt == '0) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign valid     = r_valid;

endmodule

// File: rtl/multi_cycle_unit.sv
// Multi-cycle MUL/MADD/MSUB/DIV unit for the EX stage.
//   clk, rst_n : clock, async active-low reset
//   start      : launch request, accepted only in IDLE
//   flush      : abort any operation in progress (beats start)
//   inst       : opcode
//   op1, op2   : rs / rt operands
//   hilo_i     : current {HI,LO} for MADD/MSUB
//   result     : {hi,lo}; divide gives {remainder, quotient}
//   busy       : operation in flight
//   done       : one-cycle completion pulse
//   div0       : divide-by-zero flag, valid with done
module multi_cycle_unit
  import multi_cycle_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned INST_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic [INST_W-1:0]    inst,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2*WIDTH-1:0]   hilo_i,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 div0
);

  localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(WIDTH - 1);

  mcu_state_e         r_state, w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_hilo;
  logic [2*WIDTH-1:0] r_result;
  acc_mode_e          r_acc;
  logic               r_neg_q;  // product / quotient sign
  logic               r_neg_r;  // remainder sign (dividend sign)
  logic               r_div0;

  logic [31:0]        w_op;
  logic               w_is_mul, w_is_div, w_signed, w_accept, w_wr_result;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic               w_div_valid;
  logic [2*WIDTH-1:0] w_prod_s, w_mul_res, w_res_next;

  assign w_op     = 32'(inst);
  assign w_is_mul = is_mul_class(w_op);
  assign w_is_div = is_div_class(w_op);
  assign w_signed = is_signed_op(w_op);
  assign w_abs1   = (w_signed && op1[WIDTH-1]) ? -op1 : op1;
  assign w_abs2   = (w_signed && op2[WIDTH-1]) ? -op2 : op2;
  assign w_accept = (r_state == StIdle) && start && !flush && (w_is_mul || w_is_div);

  div_iter_unsigned #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_accept && w_is_div),
    .abort     (flush),
    .dividend  (w_abs1),
    .divisor   (w_abs2),
    .quotient  (w_quo),
    .remainder (w_rem),
    .valid     (w_div_valid)
  );

  assign w_prod_s  = r_neg_q ? -r_prod : r_prod;
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  always_comb begin
    w_mul_res = w_prod_s;
    case (r_acc)
      AccAdd:  w_mul_res = r_hilo + w_prod_s;
      AccSub:  w_mul_res = r_hilo - w_prod_s;
      default: w_mul_res = w_prod_s;
    endcase
  end

  assign w_res_next  = (r_state == StFix) ? {w_rem_fix, w_quo_fix} : w_mul_res;
  assign w_wr_result = !flush && (((r_state == StMul) && (r_cnt == '0)) ||
                                  ((r_state == StFix) && w_div_valid));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_next = w_is_div ? StDiv : StMul;
      StMul: begin
        if (flush)              w_state_next = StIdle;
        else if (r_cnt == '0)   w_state_next = StDone;
      end
      StDiv: begin
        if (flush)              w_state_next = StIdle;
        else if (r_cnt == '0)   w_state_next = StFix;
      end
      StFix: begin
        if (flush)              w_state_next = StIdle;
        else if (w_div_valid)   w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_hilo   <= '0;
      r_result <= '0;
      r_acc    <= AccNone;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt   <= w_is_div ? DivLoad : MulLoad;
        // Product registered at accept so it is ready even when MUL_CYCLES is 1.
        if (w_is_mul) r_prod <= {{WIDTH{1'b0}}, w_abs1} * {{WIDTH{1'b0}}, w_abs2};
        r_hilo  <= hilo_i;
        r_acc   <= acc_mode(w_op);
        r_neg_q <= w_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
        r_neg_r <= w_signed && op1[WIDTH-1];
        r_div0  <= w_is_div && (op2 == '0);
      end else if (((r_state == StMul) || (r_state == StDiv)) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_wr_result) r_result <= w_res_next;
    end
  end

  assign result = r_result;
  assign busy   = (r_state == StMul) || (r_state == StDiv) || (r_state == StFix);
  assign done   = (r_state == StDone);
  assign div0   = done && r_div0;

endmodule

// File: tb/tb_multi_cycle_unit.sv
module tb_multi_cycle_unit;
  import multi_cycle_unit_pkg::*;

  localparam int MulLat = 3;   // MUL_CYCLES + 1
  localparam int DivLat = 34;  // WIDTH + 2

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [7:0]  inst;
  logic [31:0] op1, op2;
  logic [63:0] hilo_i;
  logic [63:0] result;
  logic        busy, done, div0;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_unit #(
    .WIDTH      (32),
    .MUL_CYCLES (2),
    .INST_W     (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .inst   (inst),
    .op1    (op1),
    .op2    (op2),
    .hilo_i (hilo_i),
    .result (result),
    .busy   (busy),
    .done   (done),
    .div0   (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    logic [63:0] exp;
    logic        d0;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one op in the next cycle and check latency, busy, result and div0.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    inst = v.inst; op1 = v.a; op2 = v.b; hilo_i = v.h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({v.name, " busy"}, 64'(busy), 64'(1));
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " latency"}, 64'(n), 64'(v.lat));
    check({v.name, " result"}, result, v.exp);
    check({v.name, " div0"}, 64'(div0), 64'(v.d0));
    check({v.name, " busy at done"}, 64'(busy), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    vec_t v;

    vecs[0]  = '{"divu 100/7", 8'(INST_DIVU), 32'd100, 32'd7, 64'h0,
                 {32'd2, 32'd14}, 1'b0, DivLat};
    vecs[1]  = '{"div -7/2", 8'(INST_DIV), 32'hFFFFFFF9, 32'd2, 64'h0,
                 {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, DivLat};
    // |−7| / 0 -> q all ones, r 7; then quotient negated (sign 1^0), remainder negated.
    vecs[2]  = '{"div -7/0", 8'(INST_DIV), 32'hFFFFFFF9, 32'd0, 64'h0,
                 {32'hFFFFFFF9, 32'h00000001}, 1'b1, DivLat};
    vecs[3]  = '{"mult -1*-1", 8'(INST_MULT), 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,
                 64'h1, 1'b0, MulLat};
    vecs[4]  = '{"multu max*max", 8'(INST_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,
                 64'hFFFFFFFE00000001, 1'b0, MulLat};
    vecs[5]  = '{"madd", 8'(INST_MADD), 32'd3, 32'hFFFFFFFE, 64'h10,
                 64'h0A, 1'b0, MulLat};
    vecs[6]  = '{"msubu", 8'(INST_MSUBU), 32'd1, 32'd1, 64'h0,
                 64'hFFFFFFFFFFFFFFFF, 1'b0, MulLat};
    vecs[7]  = '{"div min/-1", 8'(INST_DIV), 32'h80000000, 32'hFFFFFFFF, 64'h0,
                 {32'h0, 32'h80000000}, 1'b0, DivLat};
    vecs[8]  = '{"divu 5/0", 8'(INST_DIVU), 32'd5, 32'd0, 64'h0,
                 {32'd5, 32'hFFFFFFFF}, 1'b1, DivLat};
    vecs[9]  = '{"maddu", 8'(INST_MADDU), 32'hFFFFFFFF, 32'd2, 64'h1_0000_0000,
                 64'h2_FFFF_FFFE, 1'b0, MulLat};
    vecs[10] = '{"msub", 8'(INST_MSUB), 32'hFFFFFFFD, 32'd4, 64'h5,
                 64'h11, 1'b0, MulLat};
    vecs[11] = '{"div 7/-2", 8'(INST_DIV), 32'd7, 32'hFFFFFFFE, 64'h0,
                 {32'd1, 32'hFFFFFFFD}, 1'b0, DivLat};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    inst = '0; op1 = '0; op2 = '0; hilo_i = '0;
    repeat (2) @(negedge clk);
    check("reset result", result, 64'h0);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div0", 64'(div0), 64'(0));
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Unknown opcode is ignored.
    @(negedge clk);
    inst = 8'h00; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad opcode busy", 64'(busy), 64'(0));
    check("bad opcode result", result, {32'd1, 32'hFFFFFFFD});

    // Known result, then flush a DIV at cycle 10.
    v = '{"multu 3*5", 8'(INST_MULTU), 32'd3, 32'd5, 64'h0, 64'd15, 1'b0, MulLat};
    run_op(v);
    @(negedge clk);
    inst = 8'(INST_DIVU); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy before", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy after", 64'(busy), 64'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check("flush no done", 64'(seen), 64'(0));
    check("flush result kept", result, 64'd15);
    run_op(vecs[0]);

    // Start pulsed mid-DIV, then again in the DONE cycle.
    @(negedge clk);
    inst = 8'(INST_DIVU); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == 5);
      if (n == 5) begin
        inst = 8'(INST_MULTU); op1 = 32'd2; op2 = 32'd3;
      end
    end
    check("busy-start latency", 64'(n), 64'(DivLat));
    check("busy-start result", result, {32'd2, 32'd14});
    inst = 8'(INST_MULT); op1 = 32'd2; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done-start busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("done-start no done", 64'(done), 64'(0));
    check("done-start result", result, {32'd2, 32'd14});

    // flush beats start in IDLE.
    inst = 8'(INST_MULT); op1 = 32'd4; op2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle flush busy", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    check("idle flush result", result, {32'd2, 32'd14});

    // Asynchronous reset mid-DIV.
    inst = 8'(INST_DIV); op1 = 32'd50; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async reset result", result, 64'h0);
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    check("no done after reset", 64'(seen), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
